uart_rx_param: RTL and testbench
================================

# uart_rx_param

Parametrised oversampling UART receiver; successor to the fixed 9-bit receiver. Supports configurable data width, optional parity, one or two stop bits, an internal baud/sample divider, and a registered valid/ready output stage. Reports framing error, parity error, overrun and line break. It sits between the `rx` pad synchroniser boundary and the command/packet decoders.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal 5–9.
- `PARITY`, 0: 0 none, 1 even, 2 odd.
- `STOP_BITS`, 1: legal 1 or 2.
- `CLK_HZ`, 25_000_000: clock frequency.
- `BAUD_RATE`, 9600: line rate.
- `OVERSAMPLE`, 16: sample ticks per bit, even, ≥8.
- `clock` in 1: sole clock; all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `rx` in 1: asynchronous serial line, idle high.
- `data` out DATA_BITS: received word, LSB = first bit on the line.
- `valid` out 1: `data`/error flags hold a frame.
- `ready` in 1: consumer accepts on `valid && ready`.
- `parity_error` out 1: parity mismatch on the held frame (0 when `PARITY`=0).
- `framing_error` out 1: a stop bit sampled low on the held frame.
- `overrun` out 1: one-cycle pulse, frame dropped because the holding register was full.
- `break_detect` out 1: one-cycle pulse on a break frame.
- `busy` out 1: FSM not in IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser that resets to 1. All logic uses the synchronised value `rx_s`.
- Sample divider: DIV = CLK_HZ/(BAUD_RATE*OVERSAMPLE), truncated, minimum 1. Generates `tick`. Held cleared in IDLE. Restarts on start detection, so the first tick arrives DIV cycles later.
- Sample counter `scnt` runs 0..OVERSAMPLE-1 on `tick`. Bit counter `bcnt` counts data and stop bits.
- Mid-bit sample point M = OVERSAMPLE/2.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: `rx_s`=0 → START; clear `scnt`.
- START: at the sample point, if the bit value is 1 → IDLE (spurious start, no flags). Otherwise → DATA at the bit boundary.
- DATA: sample each bit and shift it into the shift register LSB-first. After DATA_BITS bits → PARITY if `PARITY`≠0, else STOP.
- PARITY: sample the parity bit. Compute mismatch against the XOR of the data bits (even: XOR of data and parity bit must be 0; odd: must be 1).
- STOP: sample STOP_BITS bits. Any stop bit sampled 0 sets the frame's framing error.
- Commit happens on the tick that samples the final stop bit:
  - Break (all data bits 0, parity bit 0 if present, framing error set): pulse `break_detect`, do not load the holding register, → WAIT_IDLE.
  - Otherwise, if the holding register is empty, or is accepted in this same cycle: load `data`, `parity_error`, `framing_error`; `valid`=1.
  - Otherwise, pulse `overrun` and discard the new frame; the held frame is unchanged.
  - Next state: framing error → WAIT_IDLE, else IDLE.
- WAIT_IDLE: stay until `rx_s`=1, then → IDLE. No start detection while in this state.
- `valid && ready` with no simultaneous commit: `valid` clears next cycle. `data` and the error flags hold their last value.
- Reset (any time, mid-frame included): state IDLE, all counters 0, shift register 0, outputs `data`=0, `valid`=0, `parity_error`=0, `framing_error`=0, `overrun`=0, `break_detect`=0, `busy`=0. No partial frame survives.

## Timing
- Start recognised 2–3 cycles after the `rx` falling edge (synchroniser delay).
- `valid`, `overrun` and `break_detect` assert in the cycle after the final stop-bit sampling tick (registered).
- Commit occurs mid-stop-bit, so the receiver accepts a new start edge from the following cycle. Back-to-back frames are received with no gap.
- `ready` is sampled only while `valid`=1. `data` is stable while `valid`=1 and not accepted.
- Frame length = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS bits of OVERSAMPLE ticks each.

## Configuration
- `UART_RX_MAJORITY_EN` defined: each bit value is the 2-of-3 majority of samples at `scnt` = M-1, M, M+1. The bit decision is taken on the M+1 tick.
- Not defined: each bit value is the single sample at `scnt` = M. The majority logic and its sample registers are absent.
- All other behaviour is identical in both builds.

## Test plan
- DATA_BITS=8, PARITY=0: send 0xA5 at nominal baud with `ready`=1 → one `valid` cycle, `data`=0xA5, both error flags 0.
- PARITY=1 (even): send 0x3C with parity bit 1 → `data`=0x3C, `parity_error`=1. Resend with parity bit 0 → `parity_error`=0.
- Send 0x55 with stop bit 0, then `rx` high → `framing_error`=1, `valid`=1, FSM passes through WAIT_IDLE. Next frame 0x12 is received clean.
- Hold `ready`=0 and send 0x11 then 0x22 back-to-back → `data`=0x11 held, one `overrun` pulse at the second commit. Then raise `ready` → `valid` drops.
- Hold `rx` low for 2 frame times → exactly one `break_detect` pulse, `valid` stays 0. After `rx` returns high, 0x7E is received correctly.
- Drop `reset_n` mid-DATA of 0x99, release, send 0x42 → only 0x42 is delivered. With `UART_RX_MAJORITY_EN`, a 1-tick glitch at M inside a bit does not flip that bit.

Source files
------------

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: configurable width/parity/stop bits, holding register with valid/ready.
// Latency: valid/overrun/break_detect assert one cycle after the tick that samples the final stop bit.
// Backpressure: one-frame holding register; a frame completing while it is full and not accepted is dropped with overrun.
//
// Ports: clock, reset_n (async active-low), rx (raw line, idle high), ready (consumer accept),
//        data/valid/parity_error/framing_error (held frame), overrun/break_detect (1-cycle pulses), busy.
// Build option: define UART_RX_MAJORITY_EN for 2-of-3 majority voting at samples M-1, M, M+1.
module uart_rx_param #(
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int CLK_HZ     = 25_000_000,
   parameter int BAUD_RATE  = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 rx,
   input  logic                 ready,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   output logic                 parity_error,
   output logic                 framing_error,
   output logic                 overrun,
   output logic                 break_detect,
   output logic                 busy
);

   localparam int DIV_RAW = CLK_HZ / (BAUD_RATE * OVERSAMPLE);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int DCW     = $clog2(DIV + 1);
   localparam int SCW     = $clog2(OVERSAMPLE);
   localparam int M       = OVERSAMPLE / 2;
`ifdef UART_RX_MAJORITY_EN
   localparam int SAMPLE_PT = M + 1;   // decision waits for the third vote
`else
   localparam int SAMPLE_PT = M;
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
   } state_t;

   state_t               state_q, state_d;
   logic                 rx_m, rx_s;
   logic [DCW-1:0]       dcnt;
   logic [SCW-1:0]       scnt;
   logic [3:0]           bcnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit;
   logic                 ferr_acc;
   logic                 in_frame, tick, sample_now, bit_end, bit_val;
   logic                 commit, ferr_now, brk, par_x, perr;

   // Two-flop synchroniser; resets to the idle level so reset never looks like a start bit.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   assign in_frame   = (state_q == S_START) || (state_q == S_DATA) ||
                       (state_q == S_PARITY) || (state_q == S_STOP);
   assign tick       = in_frame && (dcnt == DCW'(DIV - 1));
   assign sample_now = tick && (scnt == SCW'(SAMPLE_PT));
   assign bit_end    = tick && (scnt == SCW'(OVERSAMPLE - 1));

   // Divider and sample counter are held at zero outside a frame, so both restart cleanly at start detection.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         dcnt <= '0;
         scnt <= '0;
      end else if (!in_frame) begin
         dcnt <= '0;
         scnt <= '0;
      end else begin
         dcnt <= tick ? '0 : dcnt + DCW'(1);
         if (tick) scnt <= bit_end ? '0 : scnt + SCW'(1);
      end
   end

`ifdef UART_RX_MAJORITY_EN
   logic vote_a, vote_b;
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         vote_a <= 1'b1;
         vote_b <= 1'b1;
      end else begin
         if (tick && scnt == SCW'(M - 1)) vote_a <= rx_s;
         if (tick && scnt == SCW'(M))     vote_b <= rx_s;
      end
   end
   assign bit_val = (vote_a & vote_b) | (vote_a & rx_s) | (vote_b & rx_s);
`else
   assign bit_val = rx_s;
`endif

   // Frame evaluation, valid on the final stop-bit sample.
   assign ferr_now = ferr_acc | ~bit_val;
   assign par_x    = ^{shreg, par_bit};
   assign perr     = (PARITY == 1) ? par_x : (PARITY == 2) ? ~par_x : 1'b0;
   assign brk      = ferr_now && (shreg == '0) && ((PARITY == 0) || !par_bit);

   always_comb begin
      state_d = state_q;
      commit  = 1'b0;
      case (state_q)
         S_IDLE:      if (!rx_s) state_d = S_START;
         S_START: begin
            if (sample_now && bit_val) state_d = S_IDLE;   // glitch, not a real start bit
            else if (bit_end)          state_d = S_DATA;
         end
         S_DATA:      if (bit_end && bcnt == 4'(DATA_BITS))
                         state_d = (PARITY != 0) ? S_PARITY : S_STOP;
         S_PARITY:    if (bit_end) state_d = S_STOP;
         S_STOP: begin
            if (sample_now && bcnt == 4'(STOP_BITS - 1)) begin
               commit  = 1'b1;
               state_d = ferr_now ? S_WAIT_IDLE : S_IDLE;
            end
         end
         S_WAIT_IDLE: if (rx_s) state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Datapath registers; bcnt restarts on every state change.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bcnt     <= '0;
         shreg    <= '0;
         par_bit  <= 1'b0;
         ferr_acc <= 1'b0;
      end else begin
         if (state_d != state_q)
            bcnt <= '0;
         else if (sample_now && (state_q == S_DATA || state_q == S_STOP))
            bcnt <= bcnt + 4'd1;
         if (state_q == S_IDLE)
            ferr_acc <= 1'b0;
         else if (state_q == S_STOP && sample_now && !bit_val)
            ferr_acc <= 1'b1;
         if (state_q == S_DATA && sample_now)
            shreg <= {bit_val, shreg[DATA_BITS-1:1]};
         if (state_q == S_PARITY && sample_now)
            par_bit <= bit_val;
      end
   end

   // Holding register. A commit in the same cycle as an accept refills it without a bubble.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         data          <= '0;
         valid         <= 1'b0;
         parity_error  <= 1'b0;
         framing_error <= 1'b0;
         overrun       <= 1'b0;
         break_detect  <= 1'b0;
      end else begin
         overrun      <= 1'b0;
         break_detect <= 1'b0;
         if (valid && ready) valid <= 1'b0;
         if (commit) begin
            if (brk) begin
               break_detect <= 1'b1;
            end else if (!valid || ready) begin
               data          <= shreg;
               parity_error  <= perr;
               framing_error <= ferr_now;
               valid         <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end
      end
   end

   assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: two instances (no parity / 1 stop, even parity / 2 stops).
// Bit period is 32 clocks (DIV 4, oversample 8); stimulus and sampling happen on falling edges.
// Expected values are hand-derived constants; a monitor counts accepts and pulses per instance.
module tb_uart_rx_param;

   localparam int BIT_CYC = 32;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       rx0, rx1, ready0, ready1;
   logic [7:0] data0, data1;
   logic       valid0, perr0, ferr0, ovr0, brk0, busy0;
   logic       valid1, perr1, ferr1, ovr1, brk1, busy1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   uart_rx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLK_HZ(32_000_000),
                   .BAUD_RATE(1_000_000), .OVERSAMPLE(8)) dut0 (
      .clock(clock), .reset_n(reset_n), .rx(rx0), .ready(ready0), .data(data0),
      .valid(valid0), .parity_error(perr0), .framing_error(ferr0), .overrun(ovr0),
      .break_detect(brk0), .busy(busy0));

   uart_rx_param #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .CLK_HZ(32_000_000),
                   .BAUD_RATE(1_000_000), .OVERSAMPLE(8)) dut1 (
      .clock(clock), .reset_n(reset_n), .rx(rx1), .ready(ready1), .data(data1),
      .valid(valid1), .parity_error(perr1), .framing_error(ferr1), .overrun(ovr1),
      .break_detect(brk1), .busy(busy1));

   // Monitor: record every accepted frame and count pulses.
   int         acc0 = 0, ovc0 = 0, bkc0 = 0, acc1 = 0;
   logic [7:0] ld0 = '0, ld1 = '0;
   logic       lperr0 = 0, lferr0 = 0, lbusy0 = 0, lperr1 = 0, lferr1 = 0;

   always @(negedge clock) begin
      if (valid0 && ready0) begin
         acc0++; ld0 = data0; lperr0 = perr0; lferr0 = ferr0; lbusy0 = busy0;
      end
      if (valid1 && ready1) begin
         acc1++; ld1 = data1; lperr1 = perr1; lferr1 = ferr1;
      end
      if (ovr0) ovc0++;
      if (brk0) bkc0++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic set_line(input bit which, input logic v);
      if (which) rx1 = v;
      else       rx0 = v;
   endtask

   // One frame; glitch_bit >= 0 inverts that frame bit for one sample-tick window around its midpoint.
   task automatic send(input bit which, input logic [7:0] d, input bit has_par, input bit par,
                       input int nstop, input bit stop_v, input int glitch_bit);
      int   nb;
      logic v;
      nb = 1 + 8 + (has_par ? 1 : 0) + nstop;
      for (int i = 0; i < nb; i++) begin
         if (i == 0)                v = 1'b0;
         else if (i <= 8)           v = d[i-1];
         else if (has_par && i == 9) v = par;
         else                       v = stop_v;
         for (int k = 0; k < BIT_CYC; k++) begin
            set_line(which, (i == glitch_bit && k >= 19 && k < 23) ? ~v : v);
            @(negedge clock);
         end
      end
      set_line(which, 1'b1);
   endtask

   int a0, o0, b0;

   initial begin
      reset_n = 1'b0; rx0 = 1'b1; rx1 = 1'b1; ready0 = 1'b1; ready1 = 1'b1;
      idle(4);
      check("rst_data",  data0, 8'h00);
      check("rst_valid", valid0, 0);
      check("rst_perr",  perr0, 0);
      check("rst_ferr",  ferr0, 0);
      check("rst_ovr",   ovr0, 0);
      check("rst_brk",   brk0, 0);
      check("rst_busy",  busy0, 0);
      check("rst_valid1", valid1, 0);
      reset_n = 1'b1;
      idle(10);

      // Clean frame, no parity.
      a0 = acc0;
      send(0, 8'hA5, 0, 0, 1, 1, -1); idle(10);
      check("a5_count", acc0 - a0, 1);
      check("a5_data",  ld0, 8'hA5);
      check("a5_perr",  lperr0, 0);
      check("a5_ferr",  lferr0, 0);
      check("a5_busy",  lbusy0, 0);

      // Even parity: 0x3C has four ones, so parity bit 1 is wrong and 0 is right.
      send(1, 8'h3C, 1, 1, 2, 1, -1); idle(10);
      check("p1_count", acc1, 1);
      check("p1_data",  ld1, 8'h3C);
      check("p1_perr",  lperr1, 1);
      check("p1_ferr",  lferr1, 0);
      send(1, 8'h3C, 1, 0, 2, 1, -1); idle(10);
      check("p0_count", acc1, 2);
      check("p0_perr",  lperr1, 0);

      // Framing error: delivered, receiver waits for idle line.
      a0 = acc0;
      send(0, 8'h55, 0, 0, 1, 0, -1); idle(10);
      check("fe_count", acc0 - a0, 1);
      check("fe_data",  ld0, 8'h55);
      check("fe_ferr",  lferr0, 1);
      check("fe_busy_wait", lbusy0, 1);
      send(0, 8'h12, 0, 0, 1, 1, -1); idle(10);
      check("fe_next_data", ld0, 8'h12);
      check("fe_next_ferr", lferr0, 0);
      check("fe_next_busy", lbusy0, 0);

      // Overrun: hold ready low across two back-to-back frames.
      ready0 = 1'b0; a0 = acc0; o0 = ovc0;
      send(0, 8'h11, 0, 0, 1, 1, -1);
      send(0, 8'h22, 0, 0, 1, 1, -1); idle(10);
      check("ov_valid", valid0, 1);
      check("ov_data",  data0, 8'h11);
      check("ov_pulse", ovc0 - o0, 1);
      ready0 = 1'b1; idle(2);
      check("ov_drop_valid", valid0, 0);
      check("ov_hold_data",  data0, 8'h11);
      check("ov_acc", acc0 - a0, 1);

      // Break: line low for two frame times.
      a0 = acc0; b0 = bkc0;
      rx0 = 1'b0; idle(2 * 10 * BIT_CYC);
      check("brk_busy_low", busy0, 1);
      rx0 = 1'b1; idle(40);
      check("brk_pulse", bkc0 - b0, 1);
      check("brk_valid", valid0, 0);
      check("brk_acc",   acc0 - a0, 0);
      send(0, 8'h7E, 0, 0, 1, 1, -1); idle(10);
      check("brk_next_data", ld0, 8'h7E);
      check("brk_next_acc",  acc0 - a0, 1);

      // Reset in the middle of the data bits of 0x99.
      a0 = acc0;
      rx0 = 1'b0; idle(BIT_CYC);
      rx0 = 1'b1; idle(BIT_CYC);
      rx0 = 1'b0; idle(BIT_CYC + 5);
      check("mid_busy", busy0, 1);
      reset_n = 1'b0; idle(3);
      check("mid_rst_busy",  busy0, 0);
      check("mid_rst_valid", valid0, 0);
      rx0 = 1'b1; idle(2);
      reset_n = 1'b1; idle(40);
      check("mid_no_frame", acc0 - a0, 0);
      send(0, 8'h42, 0, 0, 1, 1, -1); idle(10);
      check("mid_next_acc",  acc0 - a0, 1);
      check("mid_next_data", ld0, 8'h42);

`ifdef UART_RX_MAJORITY_EN
      // Single-tick glitch on data bit 1 (frame bit 2) is outvoted.
      send(0, 8'h42, 0, 0, 1, 1, 2); idle(10);
      check("maj_glitch_data", ld0, 8'h42);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
